// File: rtl/if_id_buf_pkg.sv
// Shared encodings, widths and field positions for the IF/ID skid buffer.
package if_id_buf_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int REG_W  = 5;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } slot_t;

    function automatic logic [REG_W-1:0] get_rs(input logic [INST_W-1:0] inst);
        return inst[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_W-1:0] get_rt(input logic [INST_W-1:0] inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/if_id_buf_pipe_slot.sv
// Load-enabled {pc, inst} holding register; zero on reset.
// Latency one cycle from load to q; no flow control of its own.
module pipe_slot
    import if_id_buf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    slot_t slot_d;
    slot_t slot_q;

    always_comb begin
        slot_d = slot_q;
        if (load) slot_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign q = slot_q;

endmodule

// File: rtl/if_id_buf.sv
// IF/ID buffer: ID slot plus one skid slot; fetch-to-ID latency one cycle.
// Backpressure: if_ready drops only when both slots are full; flush empties both.
module if_id_buf
    import if_id_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              id_stall,
    input  logic              id_flush,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [REG_W-1:0]  id_rs,
    output logic [REG_W-1:0]  id_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic             id_load, id_from_skid, skid_load;
    logic             accept, advance;
    slot_t            in_slot, id_slot_d, id_slot_q, skid_slot_q;

    assign if_ready = (state_q != ST_TWO);
    assign id_valid = (state_q != ST_EMPTY);
    assign accept   = if_valid && if_ready;
    assign advance  = id_valid && !id_stall;
    assign in_slot  = '{pc: if_pc, inst: if_inst};

    always_comb begin
        state_d      = state_q;
        id_load      = 1'b0;
        id_from_skid = 1'b0;
        skid_load    = 1'b0;
        // Flush wins over stall and drops whatever fetch offers this cycle.
        if (id_flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        id_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (advance && accept) begin
                        id_load = 1'b1;
                    end else if (advance) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (advance) begin
                        state_d      = ST_ONE;
                        id_load      = 1'b1;
                        id_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign id_slot_d = id_from_skid ? skid_slot_q : in_slot;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid && id_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_slot u_id_slot (
        .clk  (clk),
        .rst  (rst),
        .load (id_load),
        .d    (id_slot_d),
        .q    (id_slot_q)
    );

    pipe_slot u_skid_slot (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_slot),
        .q    (skid_slot_q)
    );

    assign id_pc     = id_slot_q.pc;
    assign id_inst   = id_slot_q.inst;
    assign id_rs     = id_valid ? get_rs(id_slot_q.inst) : '0;
    assign id_rt     = id_valid ? get_rt(id_slot_q.inst) : '0;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_buf.sv
module tb_if_id_buf;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_stall;
    logic        id_flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    if_id_buf dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_ready  (if_ready),
        .id_stall  (id_stall),
        .id_flush  (id_flush),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_stall = 1'b0;
        id_flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst: got %h want 0", id_inst); end
        checks++; if (id_rs !== 5'd0 || id_rt !== 5'd0) begin errors++; $display("FAIL rst_rs_rt: got %0d/%0d want 0/0", id_rs, id_rt); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_if_ready: got %b want 1", if_ready); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
    endtask

    // Continues from reset: leaves the buffer in ONE holding 0xBFC00000.
    task automatic test_first_fetch();
        if_valid = 1'b1; if_pc = 32'hBFC00000; if_inst = 32'h8C220004;
        step();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ff_id_valid: got %b want 1", id_valid); end
        checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL ff_id_pc: got %h want bfc00000", id_pc); end
        checks++; if (id_inst !== 32'h8C220004) begin errors++; $display("FAIL ff_id_inst: got %h want 8c220004", id_inst); end
        checks++; if (id_rs !== 5'd1) begin errors++; $display("FAIL ff_id_rs: got %0d want 1", id_rs); end
        checks++; if (id_rt !== 5'd2) begin errors++; $display("FAIL ff_id_rt: got %0d want 2", id_rt); end
    endtask

    // Continues from ONE(0xBFC00000): leaves ONE(0xBFC00004), stall_cnt=2.
    task automatic test_stall_skid();
        id_stall = 1'b1;
        if_valid = 1'b1; if_pc = 32'hBFC00004; if_inst = 32'h8C230008;
        step();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL sk_if_ready: got %b want 0", if_ready); end
        checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL sk_id_pc_hold: got %h want bfc00000", id_pc); end
        if_pc = 32'hDEAD0000; if_inst = 32'hDEADBEEF;
        step();
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'hBFC00000 || id_inst !== 32'h8C220004) begin errors++; $display("FAIL sk_hold2: got %h/%h want bfc00000/8c220004", id_pc, id_inst); end
        id_stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'hBFC00004 || id_inst !== 32'h8C230008) begin errors++; $display("FAIL sk_release: got %h/%h want bfc00004/8c230008", id_pc, id_inst); end
        checks++; if (id_valid !== 1'b1 || if_ready !== 1'b1) begin errors++; $display("FAIL sk_state_one: valid=%b ready=%b want 1/1", id_valid, if_ready); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL sk_stall_cnt: got %0d want 2", stall_cnt); end
    endtask

    // Continues from ONE(0xBFC00004).
    task automatic test_flush();
        id_stall = 1'b1;
        if_valid = 1'b1; if_pc = 32'hBFC00008; if_inst = 32'h8C240010;
        step();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fl_two: ready got %b want 0", if_ready); end
        id_flush = 1'b1; if_pc = 32'hBFC0000C; if_inst = 32'h8C25000C;
        step();
        id_flush = 1'b0; id_stall = 1'b0; if_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_id_valid: got %b want 0", id_valid); end
        checks++; if (id_rs !== 5'd0 || id_rt !== 5'd0) begin errors++; $display("FAIL fl_rs_rt: got %0d/%0d want 0/0", id_rs, id_rt); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fl_if_ready: got %b want 1", if_ready); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_no_resurrect: got %b want 0", id_valid); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL fl_stall_cnt: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h1000 + 32'(i) * 4; if_inst = 32'h00A00000 + 32'(i);
            step();
            checks++; if (id_pc !== 32'h1000 + 32'(i) * 4 || id_valid !== 1'b1) begin errors++; $display("FAIL b2b_%0d: got %h v=%b want %h v=1", i, id_pc, id_valid, 32'h1000 + 32'(i) * 4); end
        end
        if_valid = 1'b0;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] pat;
        int sent;
        int recv;
        bit acc;
        bit adv;
        pat  = 32'b1011_0010_1101_0011_0110_1110_0100_1101;
        sent = 0;
        recv = 0;
        do_reset();
        for (int c = 0; c < 60 && recv < 8; c++) begin
            if_valid = (sent < 8);
            if_pc    = 32'h00400000 + 32'(sent) * 4;
            if_inst  = 32'h20000000 + 32'(sent) * 32'h00210001;
            id_stall = pat[c % 32];
            acc = if_valid && if_ready;
            adv = id_valid && !id_stall;
            if (adv) begin
                checks++;
                if (id_pc !== 32'h00400000 + 32'(recv) * 4 || id_inst !== 32'h20000000 + 32'(recv) * 32'h00210001) begin
                    errors++;
                    $display("FAIL stream_item_%0d: got %h/%h want %h/%h", recv, id_pc, id_inst,
                             32'h00400000 + 32'(recv) * 4, 32'h20000000 + 32'(recv) * 32'h00210001);
                end
                recv++;
            end
            step();
            if (acc) sent++;
        end
        if_valid = 1'b0; id_stall = 1'b0;
        checks++; if (recv != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", recv); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", id_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        if_valid = 1'b1; if_pc = 32'h0000ABC0; if_inst = 32'h8C220004;
        id_stall = 1'b1;
        step();
        if_valid = 1'b0;
        repeat (65534) step();
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", stall_cnt); end
        repeat (4465) step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        checks++; if (id_pc !== 32'h0000ABC0 || id_valid !== 1'b1) begin errors++; $display("FAIL sat_id_hold: got %h v=%b want 0000abc0 v=1", id_pc, id_valid); end
        id_stall = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        if_valid = 1'b1; if_pc = 32'h00001111; if_inst = 32'h8C220004;
        step();
        id_stall = 1'b1; if_pc = 32'h00002222; if_inst = 32'h8C230008;
        step();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL ar_two: ready got %b want 0", if_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL ar_state: valid=%b ready=%b want 0/1", id_valid, if_ready); end
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL ar_slot: got %h/%h want 0/0", id_pc, id_inst); end
        checks++; if (stall_cnt !== 16'h0 || id_rs !== 5'd0 || id_rt !== 5'd0) begin errors++; $display("FAIL ar_misc: cnt=%h rs=%0d rt=%0d want 0", stall_cnt, id_rs, id_rt); end
        if_valid = 1'b0; id_stall = 1'b0;
        step();
        rst = 1'b0;
        // Skid must have been cleared: a single accept+drain must expose nothing stale.
        if_valid = 1'b1; if_pc = 32'h00003333; if_inst = 32'h8C240010;
        step();
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'h00003333 || id_valid !== 1'b1) begin errors++; $display("FAIL ar_restart: got %h v=%b want 00003333 v=1", id_pc, id_valid); end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_stall = 1'b0; id_flush = 1'b0;
        test_reset();
        test_first_fetch();
        test_stall_skid();
        test_flush();
        test_back_to_back();
        test_stream();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port if_valid  input  1  fetch presents an instruction this cycle.
REQ-004 SHALL have port if_pc  input  32  PC of presented instruction.
REQ-005 SHALL have port if_inst  input  32  presented instruction word.
REQ-006 SHALL have port if_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port id_stall  input  1  ID hazard stall (from RAW-hazard detector); ID entry must hold.
REQ-008 SHALL have port id_flush  input  1  redirect; discard all buffered instructions.
REQ-009 SHALL have port id_valid  output  1  ID entry holds a live instruction.
REQ-010 SHALL have port id_pc  output  32  PC of ID entry.
REQ-011 SHALL have port id_inst  output  32  instruction of ID entry.
REQ-012 SHALL have port id_rs  output  5  id_inst[25:21], forced 0 when id_valid=0.
REQ-013 SHALL have port id_rt  output  5  id_inst[20:16], forced 0 when id_valid=0.
REQ-014 SHALL have port stall_cnt  output  16  count of cycles with id_valid && id_stall, saturating at 16'hFFFF.

Function
REQ-015 SHALL hold two entries: ID slot (drives id_*) and one skid slot; FSM states EMPTY, ONE (ID only), TWO (ID + skid).
REQ-016 SHALL define accept = if_valid && if_ready; advance = id_valid && !id_stall.
REQ-017 SHALL drive if_ready = 1 in EMPTY and ONE, 0 in TWO (combinational from state only).
REQ-018 EMPTY: accept -> ONE, ID slot loads if_pc/if_inst; else stay.
REQ-019 ONE: advance && accept -> ONE, ID slot reloads; advance only -> EMPTY; accept only -> TWO, skid loads; neither -> ONE, hold.
REQ-020 TWO: advance -> ONE, skid contents move into ID slot; else hold both.
REQ-021 id_flush SHALL override all: next state EMPTY, same-cycle incoming instruction dropped, regardless of id_stall.
REQ-022 id_valid SHALL be 1 exactly in ONE and TWO; latency fetch-to-ID is one cycle when not stalled.
REQ-023 Instruction order SHALL be preserved; no entry duplicated or lost except by flush.
REQ-024 id_pc/id_inst SHALL remain stable while id_stall=1 and no flush.
REQ-025 stall_cnt SHALL increment when id_valid && id_stall, hold at 16'hFFFF, never clear except by reset.

Reset
REQ-026 On rst: state EMPTY, id_valid 0, id_pc 0, id_inst 0, skid contents 0, stall_cnt 0, if_ready 1 (after reset release).
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Structure
REQ-028 Shared package SHALL hold state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2), widths (PC 32, INST 32, REG 5) and field positions rs[25:21], rt[20:16].
REQ-029 One sub-module pipe_slot SHALL be used twice: load-enabled, async-reset {pc, inst} register.

Verification
REQ-030 Reset then if_valid=1, pc=0xBFC00000, inst=0x8C220004, no stall -> next cycle id_valid=1, id_pc=0xBFC00000, id_rs=1, id_rt=2.
REQ-031 ONE with id_stall=1, accept pc=0xBFC00004 -> TWO, if_ready=0, id_pc unchanged; release stall -> id_pc=0xBFC00004, state ONE.
REQ-032 TWO with id_stall=1 and id_flush=1 and if_valid=1 -> EMPTY next cycle, id_valid=0, id_rs=id_rt=0, if_ready=1.
REQ-033 Stream of 8 sequential PCs with random stall pattern -> ID sees all 8 in order, none duplicated.
REQ-034 Hold id_stall=1 with id_valid=1 for 70000 cycles -> stall_cnt saturates at 0xFFFF.
REQ-035 Assert rst asynchronously while in TWO -> outputs reach reset values before next clock edge.
